instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch (IF) stage of the five-stage pipeline: owns the PC, issues requests to instruction memory and loads the IF/ID pipeline register with `pc4`/`inst`. It also consumes the next-PC controls produced by the ID stage (`pcsource`, `bpc`, `jpc`, register target). It sits upstream of `instruction_decode` and closes the branch/jump loop. Memory may take a variable number of cycles, and the stage honours a stall from the hazard logic.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INST`, 32'h0000_0000, value driven on `inst` for bubbles
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `stall` in 1: ID cannot accept; hold PC and IF/ID
- `pcsource` in 2: 00 sequential, 01 `bpc`, 10 `ra`, 11 `jpc`; meaningful only when `if_valid`=1
- `bpc`, `jpc`, `ra` in 32 each: branch, jump and jump-register targets from ID
- `imem_req` out 1: fetch request
- `imem_addr` out 32: fetch address (= `pc`)
- `imem_rdata` in 32: instruction word, valid with `imem_ack`
- `imem_ack` in 1: request complete; may assert in the same cycle as `imem_req`
- `pc` out 32: current fetch PC
- `pc4` out 32: registered fetched PC + 4 (IF/ID)
- `inst` out 32: registered instruction (IF/ID)
- `if_valid` out 1: IF/ID holds a real instruction

## Operation
- Reset values: `pc`=RESET_PC, `pc4`=0, `inst`=NOP_INST, `if_valid`=0, `imem_req`=0, state REQ, redirect-pending=0, squash=0.
- FSM state REQ:
  - `imem_req`=1 and `imem_addr`=`pc`. The address is held stable until ack.
  - On ack with `stall`=0: IF/ID loads {`pc`+4, `imem_rdata`, valid=1}, PC advances, and the FSM stays in REQ.
  - On ack with `stall`=1: the word goes into a one-entry hold buffer and the FSM enters HOLD.
  - No ack with `stall`=0: IF/ID loads a bubble (`inst`=NOP_INST, `if_valid`=0, `pc4` unchanged).
  - No ack with `stall`=1: IF/ID holds its contents.
- FSM state HOLD:
  - `imem_req`=0.
  - When `stall`=0: IF/ID loads from the hold buffer, PC advances, and the FSM returns to REQ.
- Redirect is taken when `if_valid`=1, `stall`=0 and `pcsource`≠00.
  - The target is selected per `pcsource`, with bits [1:0] forced to 00.
  - Target and pending=1 are latched.
- PC advance selects, in priority order: redirect this cycle, else pending target, else `pc`+4. Pending clears whenever the PC advances.
- The fetch that is in flight or next at redirect time is the delay-slot instruction. It executes normally unless flushing is configured (see Configuration).
- Arithmetic: `pc`+4 is modulo 2^32, so 0xFFFF_FFFC+4 = 0.
- Reset mid-request abandons the outstanding fetch. Any ack arriving in the reset cycle is ignored.

## Timing
- With zero-wait memory (ack in the request cycle), throughput is 1 instruction/cycle. An instruction fetched in cycle N appears on `inst` in N+1.
- With k wait cycles, `imem_addr` is held for k+1 cycles and k bubbles enter IF/ID.
- `imem_req` deasserts in the first HOLD cycle. It reasserts in the cycle after the stall release.
- Redirect penalty:
  - 1 delay-slot instruction, with zero-wait memory.
  - The target address appears on `imem_addr` in the cycle after the delay-slot fetch completes.
- If a redirect and an ack happen in the same cycle, the acked word is the delay slot.

## Configuration
- `IF_FLUSH_EN` defined:
  - A redirect sets squash.
  - The next completed fetch (the delay slot) enters IF/ID as a bubble (`if_valid`=0, `inst`=NOP_INST), and squash then clears.
  - A same-cycle ack is squashed immediately.
- Not defined: there is no squash logic and the delay slot enters IF/ID with `if_valid`=1.

## Test plan
- Reset: `rst`=1 for 2 cycles, RESET_PC=0 → `pc`=0, `if_valid`=0, `inst`=0, `imem_req`=0. In the first cycle after reset, `imem_req`=1 and `imem_addr`=0.
- Zero-wait stream, ack held at 1, `imem_rdata`=addr^0xA5A5_A5A5 → on consecutive cycles `pc4`=4, 8, 12 with `inst` = 0xA5A5_A5A5, 0xA5A5_A5A1, 0xA5A5_A5AD and `if_valid`=1 each cycle.
- Wait states, ack 3 cycles after request at 0x10 → `imem_addr`=0x10 for 4 cycles and 3 bubbles with `if_valid`=0. Then `pc4`=0x14 and `pc`=0x14.
- Stall on ack, `stall`=1 for 3 cycles coinciding with ack at 0x20 → `imem_req`=0 while stalled and IF/ID unchanged. On release, `inst` = word@0x20, `pc4`=0x24, and a fetch is issued at 0x24.
- Branch, instruction at 0x8 in ID with `pcsource`=01 and `bpc`=0x40 → the fetch sequence is 0xC then 0x40.
  - Without IF_FLUSH_EN, 0xC has `if_valid`=1.
  - With IF_FLUSH_EN, 0xC enters IF/ID with `if_valid`=0.
- jr and wrap:
  - `pcsource`=10 with `ra`=0x103 → fetch at 0x100.
  - A fetch at 0xFFFF_FFFC → `pc4`=0, next `pc`=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake and loads the IF/ID register.
// Optional build macro IF_FLUSH_EN turns the delay slot after a redirect into a bubble.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        if_valid
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] hold_inst;
    logic [31:0] pend_pc;
    logic        pend_valid;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_sel;
    logic [31:0] redirect_target;
    logic [31:0] next_pc;
    logic [31:0] load_word;
    logic        in_req;
    logic        capture;
    logic        advance;
    logic        redirect;
    logic        squash_now;

    assign in_req    = (state == S_REQ);
    // Request follows the state register but drops during reset so a reset cycle never issues a fetch.
    assign imem_req  = in_req && !rst;
    assign imem_addr = pc;

    assign pc_plus4  = pc + 32'd4;
    assign capture   = in_req && imem_ack && stall;
    assign advance   = !stall && ((in_req && imem_ack) || (state == S_HOLD));
    assign redirect  = if_valid && !stall && (pcsource != 2'b00);
    assign load_word = (state == S_HOLD) ? hold_inst : imem_rdata;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        redirect_sel = pc_plus4;
        case (pcsource)
            2'b01:   redirect_sel = bpc;
            2'b10:   redirect_sel = ra;
            2'b11:   redirect_sel = jpc;
            default: redirect_sel = pc_plus4;
        endcase
        redirect_target = redirect_sel & ~32'h0000_0003;
    end

    // A redirect seen this cycle beats an older pending target, which beats sequential flow.
    always_comb begin
        next_pc = pc_plus4;
        if (redirect)
            next_pc = redirect_target;
        else if (pend_valid)
            next_pc = pend_pc;
    end

`ifdef IF_FLUSH_EN
    logic squash;

    always_ff @(posedge clk) begin
        if (rst)
            squash <= 1'b0;
        else if (advance)
            squash <= 1'b0;
        else if (redirect)
            squash <= 1'b1;
    end

    // A redirect coinciding with the completing fetch squashes that fetch directly.
    assign squash_now = squash || redirect;
`else
    assign squash_now = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            pc4        <= 32'h0000_0000;
            inst       <= NOP_INST;
            if_valid   <= 1'b0;
            pend_valid <= 1'b0;
        end else begin
            if (advance) begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
            end else if (redirect) begin
                pend_valid <= 1'b1;
            end

            if (advance) begin
                if (squash_now) begin
                    inst     <= NOP_INST;
                    if_valid <= 1'b0;
                end else begin
                    pc4      <= pc_plus4;
                    inst     <= load_word;
                    if_valid <= 1'b1;
                end
            end else if (!stall) begin
                // Memory still busy: feed a bubble downstream, pc4 keeps its last value.
                inst     <= NOP_INST;
                if_valid <= 1'b0;
            end

            case (state)
                S_REQ:   if (imem_ack && stall) state <= S_HOLD;
                S_HOLD:  if (!stall) state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end
    end

    // NOTE: data-only storage is left unreset; it is always written before its qualifier marks it live.
    always_ff @(posedge clk) begin
        if (capture)
            hold_inst <= imem_rdata;
        if (redirect && !advance)
            pend_pc <= redirect_target;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// scored against a transaction-level model (acked-address queue and program-flow tracking).
module tb_instruction_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IF_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, ra;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] pc, pc4, inst;
    logic        if_valid;

    int n_cmp = 0;
    int n_bad = 0;

    instruction_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .ra         (ra),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .pc         (pc),
        .pc4        (pc4),
        .inst       (inst),
        .if_valid   (if_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b1;
        stall    = 1'b0;
        pcsource = 2'b00;
        bpc      = '0;
        jpc      = '0;
        ra       = '0;
        tick();
        tick();
    endtask

    // Reset, then fetch sequentially with zero-wait memory until pc reaches target.
    task automatic run_to(input logic [31:0] target);
        bit reached;
        do_reset();
        rst      = 1'b0;
        imem_ack = 1'b1;
        reached  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pc == target) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!reached) begin
            n_bad++;
            $display("FAIL run_to: pc=%h never reached %h", pc, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_cmp++; if (pc4 !== 32'h0) begin n_bad++; $display("FAIL reset_pc4: got %h want 0", pc4); end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_cmp++; if (inst !== NOP) begin n_bad++; $display("FAIL reset_inst: got %h want %h", inst, NOP); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        rst      = 1'b0;
        imem_ack = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL post_reset_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        rst      = 1'b0;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i) * 32'd4;
            tick();
            n_cmp++; if (pc4 !== a + 32'd4) begin n_bad++; $display("FAIL zw_pc4[%0d]: got %h want %h", i, pc4, a + 32'd4); end
            n_cmp++; if (inst !== mem_word(a)) begin n_bad++; $display("FAIL zw_inst[%0d]: got %h want %h", i, inst, mem_word(a)); end
            n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL zw_valid[%0d]: got %b want 1", i, if_valid); end
        end
    endtask

    task automatic test_wait_states();
        run_to(32'h10);
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin n_bad++; $display("FAIL ws_addr[%0d]: got req=%b addr=%h want req=1 addr=10", i, imem_req, imem_addr); end
            tick();
            n_cmp++; if (if_valid !== 1'b0 || inst !== NOP) begin n_bad++; $display("FAIL ws_bubble[%0d]: got valid=%b inst=%h want 0/%h", i, if_valid, inst, NOP); end
        end
        n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL ws_addr_last: got %h want 10", imem_addr); end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (pc4 !== 32'h14 || pc !== 32'h14) begin n_bad++; $display("FAIL ws_done: got pc4=%h pc=%h want 14/14", pc4, pc); end
        n_cmp++; if (inst !== mem_word(32'h10) || if_valid !== 1'b1) begin n_bad++; $display("FAIL ws_inst: got %h/%b want %h/1", inst, if_valid, mem_word(32'h10)); end
    endtask

    task automatic test_stall_on_ack();
        run_to(32'h20);
        stall    = 1'b1;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) stall = 1'b0;
            #1;
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL st_req[%0d]: got %b want 0", i, imem_req); end
            n_cmp++; if (pc4 !== 32'h20 || inst !== mem_word(32'h1C)) begin n_bad++; $display("FAIL st_hold[%0d]: got pc4=%h inst=%h want 20/%h", i, pc4, inst, mem_word(32'h1C)); end
        end
        imem_ack = 1'b0;
        tick();
        n_cmp++; if (inst !== mem_word(32'h20) || pc4 !== 32'h24 || if_valid !== 1'b1) begin n_bad++; $display("FAIL st_release: got inst=%h pc4=%h v=%b want %h/24/1", inst, pc4, if_valid, mem_word(32'h20)); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin n_bad++; $display("FAIL st_refetch: got req=%b addr=%h want 1/24", imem_req, imem_addr); end
    endtask

    task automatic test_branch();
        run_to(32'hC);
        pcsource = 2'b01;
        bpc      = 32'h40;
        tick();
        pcsource = 2'b00;
        n_cmp++; if (pc4 !== (FLUSH ? 32'hC : 32'h10)) begin n_bad++; $display("FAIL br_slot_pc4: got %h", pc4); end
        n_cmp++; if (if_valid !== !FLUSH) begin n_bad++; $display("FAIL br_slot_valid: got %b want %b", if_valid, !FLUSH); end
        n_cmp++; if (inst !== (FLUSH ? NOP : mem_word(32'hC))) begin n_bad++; $display("FAIL br_slot_inst: got %h", inst); end
        n_cmp++; if (imem_addr !== 32'h40) begin n_bad++; $display("FAIL br_target: got %h want 40", imem_addr); end
        tick();
        n_cmp++; if (pc4 !== 32'h44 || inst !== mem_word(32'h40) || if_valid !== 1'b1) begin n_bad++; $display("FAIL br_land: got pc4=%h inst=%h v=%b want 44/%h/1", pc4, inst, if_valid, mem_word(32'h40)); end
    endtask

    task automatic test_jr_and_wrap();
        run_to(32'hC);
        pcsource = 2'b10;
        ra       = 32'h103;
        tick();
        pcsource = 2'b00;
        n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL jr_target: got %h want 100", imem_addr); end
        tick();
        n_cmp++; if (pc4 !== 32'h104 || inst !== mem_word(32'h100)) begin n_bad++; $display("FAIL jr_land: got pc4=%h inst=%h want 104/%h", pc4, inst, mem_word(32'h100)); end
        pcsource = 2'b11;
        jpc      = 32'hFFFF_FFFF;
        tick();
        pcsource = 2'b00;
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_target: got %h want fffffffc", pc); end
        tick();
        n_cmp++; if (pc4 !== 32'h0 || inst !== mem_word(32'hFFFF_FFFC)) begin n_bad++; $display("FAIL wrap_pc4: got pc4=%h inst=%h want 0/%h", pc4, inst, mem_word(32'hFFFF_FFFC)); end
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc: got %h want 0", pc); end
    endtask

    // Randomized run: the model tracks which addresses were acknowledged, whether a word is
    // parked behind a stall, and where program flow must go after each redirect.
    task automatic test_random();
        logic [31:0] acked[$];
        logic [31:0] next_exp, tgt, a, sel;
        bit          held, have_tgt, squash, completed;
        logic        p_req, p_ack, p_stall, p_redir, p_valid;
        logic [31:0] p_addr, p_tgt, p_pc4, p_inst;

        do_reset();
        rst      = 1'b0;
        held     = 1'b0;
        have_tgt = 1'b0;
        squash   = 1'b0;
        next_exp = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_ack = ($urandom_range(0, 99) < 55);
            stall    = ($urandom_range(0, 99) < 25);
            bpc      = $urandom;
            jpc      = $urandom;
            ra       = $urandom;
            pcsource = ($urandom_range(0, 99) < 25) ? 2'($urandom_range(1, 3)) : 2'b00;
            #1;
            case (pcsource)
                2'b01:   sel = bpc;
                2'b10:   sel = ra;
                default: sel = jpc;
            endcase
            p_req   = imem_req;
            p_ack   = imem_ack;
            p_stall = stall;
            p_addr  = imem_addr;
            p_valid = if_valid;
            p_pc4   = pc4;
            p_inst  = inst;
            p_redir = if_valid && !stall && (pcsource != 2'b00);
            p_tgt   = {sel[31:2], 2'b00};
            tick();

            completed = !p_stall && ((p_req && p_ack) || held);
            if (p_req && p_ack) acked.push_back(p_addr);
            if (p_redir) begin
                have_tgt = 1'b1;
                tgt      = p_tgt;
                if (FLUSH) squash = 1'b1;
            end
            if (p_req && p_ack && p_stall) held = 1'b1;
            else if (completed) held = 1'b0;

            if (completed) begin
                a = (acked.size() != 0) ? acked.pop_front() : 32'hDEAD_BEEF;
                n_cmp++; if (a !== next_exp) begin n_bad++; $display("FAIL rnd_flow@%0d: fetched %h want %h", cyc, a, next_exp); end
                next_exp = have_tgt ? tgt : a + 32'd4;
                have_tgt = 1'b0;
                if (squash) begin
                    squash = 1'b0;
                    n_cmp++; if (if_valid !== 1'b0 || inst !== NOP) begin n_bad++; $display("FAIL rnd_squash@%0d: got v=%b inst=%h want 0/%h", cyc, if_valid, inst, NOP); end
                end else begin
                    n_cmp++; if (if_valid !== 1'b1 || inst !== mem_word(a) || pc4 !== a + 32'd4) begin n_bad++; $display("FAIL rnd_load@%0d: got v=%b inst=%h pc4=%h want 1/%h/%h", cyc, if_valid, inst, pc4, mem_word(a), a + 32'd4); end
                end
            end else if (!p_stall) begin
                n_cmp++; if (if_valid !== 1'b0 || inst !== NOP || pc4 !== p_pc4) begin n_bad++; $display("FAIL rnd_bubble@%0d: got v=%b inst=%h pc4=%h want 0/%h/%h", cyc, if_valid, inst, pc4, NOP, p_pc4); end
            end else begin
                n_cmp++; if (if_valid !== p_valid || inst !== p_inst || pc4 !== p_pc4) begin n_bad++; $display("FAIL rnd_hold@%0d: got v=%b inst=%h pc4=%h want %b/%h/%h", cyc, if_valid, inst, pc4, p_valid, p_inst, p_pc4); end
            end
            n_cmp++; if (pc !== next_exp || imem_addr !== next_exp) begin n_bad++; $display("FAIL rnd_pc@%0d: got pc=%h addr=%h want %h", cyc, pc, imem_addr, next_exp); end
            n_cmp++; if (imem_req !== !held) begin n_bad++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, imem_req, !held); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_on_ack();
        test_branch();
        test_jr_and_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
